// File: rtl/paint_job_scheduler_pkg.sv
// paint_job_scheduler_pkg: shared constants for the paint job scheduler slice.
// Holds the shape config codes, client index constants, scheduler state
// encodings and a small round-robin pointer helper.
package paint_job_scheduler_pkg;

  // Shape config codes understood by the fill engine
  localparam logic [2:0] PAINTING_CONFIG_SQUARE = 3'b000;
  localparam logic [2:0] PAINTING_CONFIG_CIRCLE = 3'b001;

  // Client slots on the request vector
  localparam logic [1:0] CLIENT_POINTER = 2'd0;
  localparam logic [1:0] CLIENT_CHESS   = 2'd1;
  localparam logic [1:0] CLIENT_UPPER   = 2'd2;

  // Cycles the scheduler waits for the engine to raise busy before it
  // treats the job as degenerate (nothing to draw)
  localparam logic [2:0] WAIT_BUSY_LIMIT = 3'd4;

  // Scheduler state encodings
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_ACK       = 3'd4
  } sched_state_e;

  // Round-robin pointer after serving 'grant': one past it, wrapping at nreq
  function automatic logic [1:0] rr_next(input logic [1:0] grant,
                                         input logic [2:0] nreq);
    logic [2:0] nxt;
    nxt = {1'b0, grant} + 3'd1;
    if (nxt >= nreq) begin
      return 2'd0;
    end else begin
      return nxt[1:0];
    end
  endfunction

endpackage

// File: rtl/paint_job_scheduler_rr_pick.sv
// rr_pick: combinational round-robin selector.
// Picks the first set request bit scanning upward from rr, wrapping modulo N.
// valid is low when no request is pending (idx is then 0).
module rr_pick
  import paint_job_scheduler_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0] req,
  input  logic [1:0]   rr,
  output logic         valid,
  output logic [1:0]   idx
);

  logic [2:0] sum;
  logic [2:0] cand;
  logic       take;
  logic       found;

  // Walk the N slots starting at rr; the first requesting slot wins
  always_comb begin
    sum   = 3'd0;
    cand  = 3'd0;
    take  = 1'b0;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 0; k < N; k++) begin
      sum   = {1'b0, rr} + 3'(k);
      cand  = (sum >= 3'(N)) ? (sum - 3'(N)) : sum;
      take  = req[cand[1:0]] & ~found;
      idx   = idx | ({2{take}} & cand[1:0]);
      found = found | take;
    end
    valid = |req;
  end

endmodule

// File: rtl/paint_job_scheduler.sv
// paint_job_scheduler: shares one rectangle/circle fill engine between NREQ
// painting clients. Round-robin arbitration, one-shot descriptor latch with
// coordinate ordering, engine start pulse, completion ack per client.
// Optional feature macro: PAINT_SCHED_TIMEOUT_EN adds a per-job watchdog of
// TMO cycles and the sticky tmo_flag output port.
module paint_job_scheduler
  import paint_job_scheduler_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int XW   = 8,
  parameter int YW   = 7,
  parameter int CW   = 3,
  parameter int TMO  = 4095
) (
  input  logic                Clck,
  input  logic                Reset,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*XW-1:0]  job_x0,
  input  logic [NREQ*XW-1:0]  job_x1,
  input  logic [NREQ*YW-1:0]  job_y0,
  input  logic [NREQ*YW-1:0]  job_y1,
  input  logic [NREQ*CW-1:0]  job_col,
  input  logic [NREQ*3-1:0]   job_cfg,
  output logic [NREQ-1:0]     ack,
  output logic [XW-1:0]       eng_x0,
  output logic [XW-1:0]       eng_x1,
  output logic [YW-1:0]       eng_y0,
  output logic [YW-1:0]       eng_y1,
  output logic [CW-1:0]       eng_col,
  output logic [2:0]          eng_cfg,
  output logic                eng_start,
  input  logic                eng_busy,
  output logic [1:0]          grant_id,
`ifdef PAINT_SCHED_TIMEOUT_EN
  output logic                tmo_flag,
`endif
  output logic                sched_busy
);

  sched_state_e state_q, state_d;
  logic [2:0]   wb_cnt_q, wb_cnt_d;
  logic [1:0]   rr_q, rr_d;
  logic [1:0]   grant_id_q, grant_id_d;
  logic [XW-1:0] eng_x0_q, eng_x0_d, eng_x1_q, eng_x1_d;
  logic [YW-1:0] eng_y0_q, eng_y0_d, eng_y1_q, eng_y1_d;
  logic [CW-1:0] eng_col_q, eng_col_d;
  logic [2:0]    eng_cfg_q, eng_cfg_d;
  logic          eng_start_q, eng_start_d;
  logic          sched_busy_q, sched_busy_d;
  logic [NREQ-1:0] ack_q, ack_d;

  logic          pick_valid;
  logic [1:0]    pick_idx;
  logic [XW-1:0] sel_x0, sel_x1;
  logic [YW-1:0] sel_y0, sel_y1;
  logic [CW-1:0] sel_col;
  logic [2:0]    sel_cfg;

`ifdef PAINT_SCHED_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_flag_q, tmo_flag_d;
  logic             tmo_hit;
`endif

  rr_pick #(.N(NREQ)) u_rr_pick (
    .req   (req),
    .rr    (rr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Mux the winning client's descriptor out of the packed request buses
  always_comb begin
    sel_x0  = '0;
    sel_x1  = '0;
    sel_y0  = '0;
    sel_y1  = '0;
    sel_col = '0;
    sel_cfg = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_x0  = sel_x0  | ({XW{pick_idx == 2'(i)}} & job_x0[i*XW +: XW]);
      sel_x1  = sel_x1  | ({XW{pick_idx == 2'(i)}} & job_x1[i*XW +: XW]);
      sel_y0  = sel_y0  | ({YW{pick_idx == 2'(i)}} & job_y0[i*YW +: YW]);
      sel_y1  = sel_y1  | ({YW{pick_idx == 2'(i)}} & job_y1[i*YW +: YW]);
      sel_col = sel_col | ({CW{pick_idx == 2'(i)}} & job_col[i*CW +: CW]);
      sel_cfg = sel_cfg | ({3{pick_idx == 2'(i)}} & job_cfg[i*3 +: 3]);
    end
  end

  // Next-state and datapath: arbitrate, latch ordered descriptor, track engine
  always_comb begin
    state_d    = state_q;
    wb_cnt_d   = wb_cnt_q;
    rr_d       = rr_q;
    grant_id_d = grant_id_q;
    eng_x0_d   = eng_x0_q;
    eng_x1_d   = eng_x1_q;
    eng_y0_d   = eng_y0_q;
    eng_y1_d   = eng_y1_q;
    eng_col_d  = eng_col_q;
    eng_cfg_d  = eng_cfg_q;
`ifdef PAINT_SCHED_TIMEOUT_EN
    tmo_cnt_d  = tmo_cnt_q;
    tmo_flag_d = tmo_flag_q;
    tmo_hit    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d    = ST_LAUNCH;
          grant_id_d = pick_idx;
          // Order the corners so the engine always sees x0<=x1, y0<=y1
          eng_x0_d   = (sel_x1 < sel_x0) ? sel_x1 : sel_x0;
          eng_x1_d   = (sel_x1 < sel_x0) ? sel_x0 : sel_x1;
          eng_y0_d   = (sel_y1 < sel_y0) ? sel_y1 : sel_y0;
          eng_y1_d   = (sel_y1 < sel_y0) ? sel_y0 : sel_y1;
          eng_col_d  = sel_col;
          eng_cfg_d  = sel_cfg;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        wb_cnt_d = 3'd0;
        state_d  = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (eng_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (wb_cnt_q == (WAIT_BUSY_LIMIT - 3'd1)) begin
          // Engine never left its idle state: empty shape, job is done
          state_d = ST_ACK;
        end else begin
          wb_cnt_d = wb_cnt_q + 3'd1;
        end
      end
      ST_WAIT_DONE: begin
        if (!eng_busy) begin
          state_d = ST_ACK;
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_ACK: begin
        rr_d    = rr_next(grant_id_q, 3'(NREQ));
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
`ifdef PAINT_SCHED_TIMEOUT_EN
    // Watchdog: clear on launch, count while waiting on the engine
    if (state_q == ST_LAUNCH) begin
      tmo_cnt_d = '0;
    end else if ((state_q == ST_WAIT_BUSY) || (state_q == ST_WAIT_DONE)) begin
      tmo_hit   = (tmo_cnt_q == TMO_W'(TMO - 1));
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end else begin
      tmo_cnt_d = tmo_cnt_q;
    end
    if (tmo_hit) begin
      state_d    = ST_ACK;
      tmo_flag_d = 1'b1;
    end else begin
      tmo_flag_d = tmo_flag_q;
    end
`endif
  end

  // Output decode from the next state so every output leaves a flop
  always_comb begin
    eng_start_d  = (state_d == ST_LAUNCH);
    sched_busy_d = (state_d != ST_IDLE);
    ack_d        = '0;
    for (int i = 0; i < NREQ; i++) begin
      ack_d[i] = (state_d == ST_ACK) && (grant_id_d == 2'(i));
    end
  end

  // State, datapath and output registers with synchronous active-low reset
  always_ff @(posedge Clck) begin
    if (!Reset) begin
      state_q      <= ST_IDLE;
      wb_cnt_q     <= 3'd0;
      rr_q         <= 2'd0;
      grant_id_q   <= 2'd0;
      eng_x0_q     <= '0;
      eng_x1_q     <= '0;
      eng_y0_q     <= '0;
      eng_y1_q     <= '0;
      eng_col_q    <= '0;
      eng_cfg_q    <= 3'd0;
      eng_start_q  <= 1'b0;
      sched_busy_q <= 1'b0;
      ack_q        <= '0;
    end else begin
      state_q      <= state_d;
      wb_cnt_q     <= wb_cnt_d;
      rr_q         <= rr_d;
      grant_id_q   <= grant_id_d;
      eng_x0_q     <= eng_x0_d;
      eng_x1_q     <= eng_x1_d;
      eng_y0_q     <= eng_y0_d;
      eng_y1_q     <= eng_y1_d;
      eng_col_q    <= eng_col_d;
      eng_cfg_q    <= eng_cfg_d;
      eng_start_q  <= eng_start_d;
      sched_busy_q <= sched_busy_d;
      ack_q        <= ack_d;
    end
  end

`ifdef PAINT_SCHED_TIMEOUT_EN
  // Watchdog counter and sticky timeout flag; only reset clears the flag
  always_ff @(posedge Clck) begin
    if (!Reset) begin
      tmo_cnt_q  <= '0;
      tmo_flag_q <= 1'b0;
    end else begin
      tmo_cnt_q  <= tmo_cnt_d;
      tmo_flag_q <= tmo_flag_d;
    end
  end

  assign tmo_flag = tmo_flag_q;
`endif

  assign ack        = ack_q;
  assign eng_x0     = eng_x0_q;
  assign eng_x1     = eng_x1_q;
  assign eng_y0     = eng_y0_q;
  assign eng_y1     = eng_y1_q;
  assign eng_col    = eng_col_q;
  assign eng_cfg    = eng_cfg_q;
  assign eng_start  = eng_start_q;
  assign grant_id   = grant_id_q;
  assign sched_busy = sched_busy_q;

endmodule

// File: tb/tb_paint_job_scheduler.sv
// tb_paint_job_scheduler: self-checking bench for paint_job_scheduler.
// Directed vector table, contention and mid-job reset sequences, then random
// client traffic checked by a transaction-level reference model.
module tb_paint_job_scheduler;
  localparam int NREQ = 3;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int CW = 3;
`ifdef PAINT_SCHED_TIMEOUT_EN
  localparam int TMO_TB = 50;
`else
  localparam int TMO_TB = 4095;
`endif
  localparam int STUCK = 1000000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*XW-1:0] job_x0, job_x1;
  logic [NREQ*YW-1:0] job_y0, job_y1;
  logic [NREQ*CW-1:0] job_col;
  logic [NREQ*3-1:0]  job_cfg;
  logic [NREQ-1:0] ack;
  logic [XW-1:0] eng_x0, eng_x1;
  logic [YW-1:0] eng_y0, eng_y1;
  logic [CW-1:0] eng_col;
  logic [2:0] eng_cfg;
  logic eng_start;
  logic eng_busy = 1'b0;
  logic [1:0] grant_id;
  logic sched_busy;
`ifdef PAINT_SCHED_TIMEOUT_EN
  logic tmo_flag;
`endif

  logic [XW-1:0] d_x0 [NREQ];
  logic [XW-1:0] d_x1 [NREQ];
  logic [YW-1:0] d_y0 [NREQ];
  logic [YW-1:0] d_y1 [NREQ];
  logic [CW-1:0] d_col [NREQ];
  logic [2:0]    d_cfg [NREQ];

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int cur_len = 1;
  int eng_cnt = 0;

  always #5 clk = ~clk;

  paint_job_scheduler #(.NREQ(NREQ), .XW(XW), .YW(YW), .CW(CW), .TMO(TMO_TB)) dut (
    .Clck(clk), .Reset(rst_n), .req(req),
    .job_x0(job_x0), .job_x1(job_x1), .job_y0(job_y0), .job_y1(job_y1),
    .job_col(job_col), .job_cfg(job_cfg), .ack(ack),
    .eng_x0(eng_x0), .eng_x1(eng_x1), .eng_y0(eng_y0), .eng_y1(eng_y1),
    .eng_col(eng_col), .eng_cfg(eng_cfg), .eng_start(eng_start),
    .eng_busy(eng_busy), .grant_id(grant_id),
`ifdef PAINT_SCHED_TIMEOUT_EN
    .tmo_flag(tmo_flag),
`endif
    .sched_busy(sched_busy)
  );

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      job_x0[i*XW +: XW] = d_x0[i];
      job_x1[i*XW +: XW] = d_x1[i];
      job_y0[i*YW +: YW] = d_y0[i];
      job_y1[i*YW +: YW] = d_y1[i];
      job_col[i*CW +: CW] = d_col[i];
      job_cfg[i*3 +: 3] = d_cfg[i];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_lat(input int len);
    if (len == 0) return 5;
    else if (len == STUCK) return TMO_TB + 1;
    else return len + 2;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Engine model: busy for cur_len cycles after a start pulse; 0 = never busy
  always @(posedge clk) begin
    if (!rst_n) begin
      eng_busy <= 1'b0;
      eng_cnt <= 0;
    end else if (eng_start && cur_len > 0) begin
      eng_busy <= 1'b1;
      eng_cnt <= cur_len;
    end else if (eng_busy && eng_cnt != STUCK) begin
      eng_cnt <= eng_cnt - 1;
      eng_busy <= (eng_cnt > 1);
    end
  end

  // Reference model: who should win each start, what ordered corners, when ack
  int m_rr = 0, m_win = -1, m_ack_cyc = 0, m_c;
  bit m_active = 1'b0;
  logic [NREQ-1:0] req_d1 = '0, ack_last = '0, exp_ack;
  always @(negedge clk) begin
    if (!rst_n) begin
      m_rr = 0;
      m_active = 1'b0;
    end else begin
      if (eng_start) begin
        check("start_engine_idle", eng_busy, 0);
        check("start_no_overlap", m_active, 0);
        m_win = -1;
        for (int k = NREQ - 1; k >= 0; k--) begin
          m_c = (m_rr + k) % NREQ;
          if (req_d1[m_c]) m_win = m_c;
        end
        check("model_grant", grant_id, m_win);
        if (m_win >= 0) begin
          check("model_x0", eng_x0, (d_x0[m_win] < d_x1[m_win]) ? d_x0[m_win] : d_x1[m_win]);
          check("model_x1", eng_x1, (d_x0[m_win] < d_x1[m_win]) ? d_x1[m_win] : d_x0[m_win]);
          check("model_y0", eng_y0, (d_y0[m_win] < d_y1[m_win]) ? d_y0[m_win] : d_y1[m_win]);
          check("model_y1", eng_y1, (d_y0[m_win] < d_y1[m_win]) ? d_y1[m_win] : d_y0[m_win]);
          check("model_col", eng_col, d_col[m_win]);
          check("model_cfg", eng_cfg, d_cfg[m_win]);
          m_active = 1'b1;
          m_ack_cyc = cyc + exp_lat(cur_len);
        end
      end
      exp_ack = '0;
      if (m_active && cyc == m_ack_cyc) exp_ack[m_win] = 1'b1;
      check("model_ack", ack, exp_ack);
      if (exp_ack != '0) begin
        m_active = 1'b0;
        m_rr = (m_win + 1) % NREQ;
      end
    end
    req_d1 = req;
    ack_last = ack;
  end

  typedef struct {
    int client;
    logic [XW-1:0] x0, x1;
    logic [YW-1:0] y0, y1;
    logic [CW-1:0] col;
    logic [2:0] cfg;
    int len;
    logic [XW-1:0] ex0, ex1;
    logic [YW-1:0] ey0, ey1;
    int lat;
  } vec_t;

  task automatic set_desc(input int c, input logic [XW-1:0] x0, input logic [XW-1:0] x1,
                          input logic [YW-1:0] y0, input logic [YW-1:0] y1,
                          input logic [CW-1:0] col, input logic [2:0] cfg);
    d_x0[c] = x0; d_x1[c] = x1; d_y0[c] = y0; d_y1[c] = y1; d_col[c] = col; d_cfg[c] = cfg;
  endtask

  task automatic new_job(input int c);
    set_desc(c, XW'($urandom_range(0, 255)), XW'($urandom_range(0, 255)),
             YW'($urandom_range(0, 127)), YW'($urandom_range(0, 127)),
             CW'($urandom_range(0, 7)), 3'($urandom_range(0, 1)));
  endtask

  // Wait (bounded) for the next start pulse; k = negedges waited
  task automatic wait_start(output int k);
    k = 0;
    @(negedge clk);
    while (!eng_start && k < 60) begin k++; @(negedge clk); end
  endtask

  // Wait (bounded) for an ack after the start cycle; a = cycles after start
  task automatic wait_ack(output int a);
    a = 1;
    @(negedge clk);
    while (ack == '0 && a < 300) begin a++; @(negedge clk); end
  endtask

  // Called just after a rising edge: run one job and compare with the table
  task automatic run_vec(input vec_t v);
    int k, a;
    logic [NREQ-1:0] oh;
    oh = '0;
    oh[v.client] = 1'b1;
    set_desc(v.client, v.x0, v.x1, v.y0, v.y1, v.col, v.cfg);
    cur_len = v.len;
    req = oh;
    wait_start(k);
    check("vec_start_lat", k, 1);
    check("vec_x0", eng_x0, v.ex0);
    check("vec_x1", eng_x1, v.ex1);
    check("vec_y0", eng_y0, v.ey0);
    check("vec_y1", eng_y1, v.ey1);
    check("vec_col", eng_col, v.col);
    check("vec_cfg", eng_cfg, v.cfg);
    check("vec_grant", grant_id, v.client);
    wait_ack(a);
    check("vec_ack_lat", a, v.lat);
    check("vec_ack_vec", ack, oh);
    @(posedge clk); #1;
    req = '0;
    @(negedge clk);
    check("vec_ack_pulse", ack, 0);
    check("vec_back_idle", sched_busy, 0);
    check("vec_hold_x0", eng_x0, v.ex0);
    @(posedge clk); #1;
  endtask

  // Drop each client's request after its ack until everything is served
  task automatic drain(input string name);
    int g;
    g = 0;
    while (req != '0 && g < 2000) begin
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) if (ack_last[i]) req[i] = 1'b0;
      g++;
    end
    check(name, req, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    req = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  vec_t vecs[5];
  int exp_order[4] = '{0, 1, 2, 0};

  initial begin
    int k, a;
    for (int i = 0; i < NREQ; i++) set_desc(i, '0, '0, '0, '0, '0, 3'd0);
    vecs[0] = '{0, 8'd10, 8'd15, 7'd20, 7'd25, 3'b100, 3'b000, 30, 8'd10, 8'd15, 7'd20, 7'd25, 32};
    vecs[1] = '{1, 8'd40, 8'd30, 7'd5,  7'd9,  3'b010, 3'b001, 3,  8'd30, 8'd40, 7'd5,  7'd9,  5};
    vecs[2] = '{2, 8'd7,  8'd7,  7'd100, 7'd60, 3'b111, 3'b000, 0, 8'd7, 8'd7, 7'd60, 7'd100, 5};
    vecs[3] = '{0, 8'd255, 8'd0, 7'd127, 7'd0, 3'b001, 3'b001, 1, 8'd0, 8'd255, 7'd0, 7'd127, 3};
    vecs[4] = '{2, 8'd0,  8'd0,  7'd0,  7'd0,  3'b011, 3'b000, 2,  8'd0, 8'd0, 7'd0, 7'd0, 4};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_sched_busy", sched_busy, 0);
    check("rst_ack", ack, 0);
    check("rst_start", eng_start, 0);
    check("rst_grant", grant_id, 0);
    check("rst_eng_x0", eng_x0, 0);
    check("rst_eng_y1", eng_y1, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Contention: all three hold req, grants rotate 0,1,2,0
    for (int i = 0; i < NREQ; i++) set_desc(i, XW'(i * 10), XW'(i * 10 + 5), YW'(i), YW'(i + 3), CW'(i), 3'd0);
    cur_len = 3;
    req = '1;
    for (int j = 0; j < 4; j++) begin
      wait_start(k);
      check("contention_order", grant_id, exp_order[j]);
    end
    wait_ack(a);
    check("contention_last_ack", ack, 3'b001);
    @(posedge clk); #1;
    req = '0;
    repeat (2) @(posedge clk); #1;

    // Directed vector table
    foreach (vecs[i]) run_vec(vecs[i]);

    // Mid-job reset: client 0 job moves rr to 1, then client 2 is abandoned
    run_vec('{0, 8'd1, 8'd2, 7'd3, 7'd4, 3'b101, 3'b000, 2, 8'd1, 8'd2, 7'd3, 7'd4, 4});
    set_desc(2, 8'd50, 8'd60, 7'd50, 7'd60, 3'b110, 3'b001);
    cur_len = 30;
    req = 3'b100;
    wait_start(k);
    check("rstjob_grant", grant_id, 2);
    repeat (5) @(negedge clk);
    check("rstjob_busy_before", sched_busy, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    set_desc(0, 8'd70, 8'd71, 7'd72, 7'd73, 3'b001, 3'b000);
    set_desc(1, 8'd80, 8'd81, 7'd82, 7'd83, 3'b010, 3'b001);
    cur_len = 2;
    req = 3'b011;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rstjob_sched_busy", sched_busy, 0);
    check("rstjob_ack", ack, 0);
    check("rstjob_start", eng_start, 0);
    check("rstjob_grant_clr", grant_id, 0);
    check("rstjob_x1_clr", eng_x1, 0);
    @(negedge clk);
    check("rstjob_regrant_start", eng_start, 1);
    check("rstjob_regrant_rr0", grant_id, 0);
    drain("rstjob_drain");
    repeat (2) @(posedge clk); #1;

    // Random traffic against the reference model
    for (int t = 0; t < 2500; t++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) begin
        if (ack_last[i]) begin
          if ($urandom_range(0, 3) == 0) new_job(i);
          else req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 5) == 0) begin
          new_job(i);
          req[i] = 1'b1;
        end
      end
      cur_len = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 8));
    end
    drain("random_drain");
    repeat (3) @(posedge clk); #1;

`ifdef PAINT_SCHED_TIMEOUT_EN
    check("tmo_flag_initial", tmo_flag, 0);
    set_desc(0, 8'd5, 8'd9, 7'd5, 7'd9, 3'b001, 3'b000);
    cur_len = STUCK;
    req = 3'b001;
    wait_start(k);
    wait_ack(a);
    check("tmo_ack_lat", a, TMO_TB + 1);
    check("tmo_flag_set", tmo_flag, 1);
    @(posedge clk); #1;
    req = '0;
    repeat (3) @(negedge clk);
    check("tmo_flag_sticky", tmo_flag, 1);
    do_reset();
    @(negedge clk);
    check("tmo_flag_reset", tmo_flag, 0);
    cur_len = 1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
